// File: rtl/fpu_seq_pkg.sv
// rtl/fpu_seq_pkg.sv - sequencer state type and fpusel opcode map shared with FPU/decode
package fpu_seq_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_t;

  localparam logic [4:0] FP_ADD    = 5'd0;
  localparam logic [4:0] FP_SUB    = 5'd1;
  localparam logic [4:0] FP_MUL    = 5'd2;
  localparam logic [4:0] FP_DIV    = 5'd3;
  localparam logic [4:0] FP_SQRT   = 5'd4;
  localparam logic [4:0] FP_FMADD  = 5'd5;
  localparam logic [4:0] FP_FMSUB  = 5'd6;
  localparam logic [4:0] FP_FNMADD = 5'd7;
  localparam logic [4:0] FP_FNMSUB = 5'd8;
  localparam logic [4:0] FP_SGNJ   = 5'd9;
  localparam logic [4:0] FP_MINMAX = 5'd10;
  localparam logic [4:0] FP_CMP    = 5'd11;
  localparam logic [4:0] FP_CLASS  = 5'd12;
  localparam logic [4:0] FP_MV     = 5'd13;
  localparam logic [4:0] FP_CVT    = 5'd14;

endpackage

// File: rtl/fpu_lat_lut.sv
// rtl/fpu_lat_lut.sv - combinational fpusel to latency table; unmapped opcodes take LAT_MISC
module fpu_lat_lut
  import fpu_seq_pkg::*;
#(
  parameter int SEL_W    = 5,
  parameter int LAT_W    = 5,
  parameter int LAT_ADD  = 3,
  parameter int LAT_MUL  = 4,
  parameter int LAT_FMA  = 5,
  parameter int LAT_DIV  = 12,
  parameter int LAT_SQRT = 12,
  parameter int LAT_MISC = 1
) (
  input  logic [SEL_W-1:0] i_sel,
  output logic [LAT_W-1:0] o_lat
);

  localparam int LAT_MAX = (1 << LAT_W) - 1;

  // A zero latency would underflow the counter load, and anything above LAT_MAX would truncate.
  if (LAT_ADD < 1 || LAT_ADD > LAT_MAX || LAT_MUL < 1 || LAT_MUL > LAT_MAX ||
      LAT_FMA < 1 || LAT_FMA > LAT_MAX || LAT_DIV < 1 || LAT_DIV > LAT_MAX ||
      LAT_SQRT < 1 || LAT_SQRT > LAT_MAX || LAT_MISC < 1 || LAT_MISC > LAT_MAX) begin : g_lat_range_err
    $error("fpu_lat_lut: every LAT_* must lie in 1..%0d", LAT_MAX);
  end

  always_comb begin
    o_lat = LAT_W'(LAT_MISC);
    case (i_sel)
      SEL_W'(FP_ADD), SEL_W'(FP_SUB):          o_lat = LAT_W'(LAT_ADD);
      SEL_W'(FP_MUL):                          o_lat = LAT_W'(LAT_MUL);
      SEL_W'(FP_FMADD), SEL_W'(FP_FMSUB),
      SEL_W'(FP_FNMADD), SEL_W'(FP_FNMSUB):    o_lat = LAT_W'(LAT_FMA);
      SEL_W'(FP_DIV):                          o_lat = LAT_W'(LAT_DIV);
      SEL_W'(FP_SQRT):                         o_lat = LAT_W'(LAT_SQRT);
      default:                                 o_lat = LAT_W'(LAT_MISC);
    endcase
  end

endmodule

// File: rtl/fpu_issue_sequencer.sv
// rtl/fpu_issue_sequencer.sv - multi-cycle FPU op sequencer with pipeline stall and rd tagging
// Optional FPU_SEQ_PERF_EN adds saturating perf_ops / perf_stall counters.
module fpu_issue_sequencer
  import fpu_seq_pkg::*;
#(
  parameter int SEL_W    = 5,
  parameter int LAT_W    = 5,
  parameter int LAT_ADD  = 3,
  parameter int LAT_MUL  = 4,
  parameter int LAT_FMA  = 5,
  parameter int LAT_DIV  = 12,
  parameter int LAT_SQRT = 12,
  parameter int LAT_MISC = 1
) (
  input  logic             clk,
  input  logic             Rst_n,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [SEL_W-1:0] issue_fpusel,
  input  logic [4:0]       issue_rd,
  input  logic [2:0]       issue_frm,
  input  logic             hold,
  input  logic             flush,
  output logic             fpu_start,
  output logic [SEL_W-1:0] fpu_sel,
  output logic [2:0]       fpu_frm,
  output logic             fpu_kill,
  output logic             f_stall,
  output logic             result_valid,
  output logic [4:0]       result_rd,
  output logic             busy
`ifdef FPU_SEQ_PERF_EN
  ,
  output logic [31:0]      perf_ops,
  output logic [31:0]      perf_stall
`endif
);

  seq_state_t       r_state;
  seq_state_t       w_next;
  logic [LAT_W-1:0] r_cnt;
  logic [LAT_W-1:0] w_lat;
  logic             w_multi;
  logic             w_accept;
  logic             w_kill;
  logic             r_start;
  logic             r_kill;
  logic [SEL_W-1:0] r_sel;
  logic [2:0]       r_frm;
  logic [4:0]       r_rd;

  fpu_lat_lut #(
    .SEL_W   (SEL_W),
    .LAT_W   (LAT_W),
    .LAT_ADD (LAT_ADD),
    .LAT_MUL (LAT_MUL),
    .LAT_FMA (LAT_FMA),
    .LAT_DIV (LAT_DIV),
    .LAT_SQRT(LAT_SQRT),
    .LAT_MISC(LAT_MISC)
  ) u_lat_lut (
    .i_sel(issue_fpusel),
    .o_lat(w_lat)
  );

  assign w_multi  = (w_lat > LAT_W'(1));
  assign w_accept = (r_state == SEQ_IDLE) && issue_valid && !hold && !flush;
  assign w_kill   = (r_state != SEQ_IDLE) && flush;

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) r_state <= SEQ_IDLE;
    else        r_state <= w_next;
  end

  // Flush outranks both RUN->DONE and DONE->IDLE; hold only matters in DONE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      SEQ_IDLE: if (w_accept) w_next = w_multi ? SEQ_RUN : SEQ_DONE;
      SEQ_RUN:  begin
        if (flush)                      w_next = SEQ_IDLE;
        else if (r_cnt <= LAT_W'(1))    w_next = SEQ_DONE;
      end
      SEQ_DONE: if (flush || !hold) w_next = SEQ_IDLE;
      default:  w_next = SEQ_IDLE;
    endcase
  end

  always_comb begin
    issue_ready  = (r_state == SEQ_IDLE) && !hold;
    f_stall      = (r_state == SEQ_RUN) || ((r_state == SEQ_IDLE) && issue_valid && w_multi);
    result_valid = (r_state == SEQ_DONE) && !flush;
    busy         = (r_state != SEQ_IDLE);
  end

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_cnt   <= '0;
      r_start <= 1'b0;
      r_kill  <= 1'b0;
      r_sel   <= '0;
      r_frm   <= '0;
      r_rd    <= '0;
    end else begin
      r_start <= w_accept;
      r_kill  <= w_kill;
      if (w_accept) begin
        r_cnt <= w_lat - LAT_W'(1);
        r_sel <= issue_fpusel;
        r_frm <= issue_frm;
        r_rd  <= issue_rd;
      end else if (w_kill) begin
        r_cnt <= '0;
      end else if (r_state == SEQ_RUN && r_cnt != '0) begin
        r_cnt <= r_cnt - LAT_W'(1);
      end
    end
  end

  assign fpu_start = r_start;
  assign fpu_kill  = r_kill;
  assign fpu_sel   = r_sel;
  assign fpu_frm   = r_frm;
  assign result_rd = r_rd;

`ifdef FPU_SEQ_PERF_EN
  logic [31:0] r_perf_ops;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_perf_ops   <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_accept && r_perf_ops != '1)  r_perf_ops   <= r_perf_ops + 32'd1;
      if (f_stall && r_perf_stall != '1) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_ops   = r_perf_ops;
  assign perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_fpu_issue_sequencer.sv
// tb/tb_fpu_issue_sequencer.sv - directed self-checking bench for fpu_issue_sequencer
module tb_fpu_issue_sequencer;
  import fpu_seq_pkg::*;

  logic       clk = 1'b0;
  logic       Rst_n;
  logic       issue_valid;
  logic       issue_ready;
  logic [4:0] issue_fpusel;
  logic [4:0] issue_rd;
  logic [2:0] issue_frm;
  logic       hold;
  logic       flush;
  logic       fpu_start;
  logic [4:0] fpu_sel;
  logic [2:0] fpu_frm;
  logic       fpu_kill;
  logic       f_stall;
  logic       result_valid;
  logic [4:0] result_rd;
  logic       busy;
`ifdef FPU_SEQ_PERF_EN
  logic [31:0] perf_ops;
  logic [31:0] perf_stall;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fpu_issue_sequencer dut (
    .clk(clk), .Rst_n(Rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_fpusel(issue_fpusel), .issue_rd(issue_rd), .issue_frm(issue_frm),
    .hold(hold), .flush(flush),
    .fpu_start(fpu_start), .fpu_sel(fpu_sel), .fpu_frm(fpu_frm), .fpu_kill(fpu_kill),
    .f_stall(f_stall), .result_valid(result_valid), .result_rd(result_rd), .busy(busy)
`ifdef FPU_SEQ_PERF_EN
    , .perf_ops(perf_ops), .perf_stall(perf_stall)
`endif
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic issue(input logic [4:0] sel, input logic [4:0] rd, input logic [2:0] frm);
    step();
    issue_valid = 1'b1; issue_fpusel = sel; issue_rd = rd; issue_frm = frm;
    hold = 1'b0; flush = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0; issue_valid = 1'b0; issue_fpusel = '0; issue_rd = '0; issue_frm = '0;
    hold = 1'b0; flush = 1'b0;
    step(); step(); #1;
    n_total++;
    if ({fpu_start, fpu_kill, f_stall, result_valid, busy, fpu_sel, fpu_frm, result_rd} !== 18'd0)
      $display("FAIL reset_outputs: got %b want 0",
               {fpu_start, fpu_kill, f_stall, result_valid, busy, fpu_sel, fpu_frm, result_rd});
    else n_pass++;
    step(); Rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_run();
    issue(FP_DIV, 5'd9, 3'd4);
    for (int c = 1; c <= 5; c++) begin
      step(); issue_valid = 1'b0; #1;
    end
    n_total++;
    if (busy !== 1'b1 || f_stall !== 1'b1) $display("FAIL div_running: busy=%b stall=%b want 1 1", busy, f_stall);
    else n_pass++;
    Rst_n = 1'b0; #1;
    n_total++;
    if ({fpu_start, fpu_kill, f_stall, result_valid, busy, fpu_sel, fpu_frm, result_rd} !== 18'd0)
      $display("FAIL async_reset_outputs: got %b want 0",
               {fpu_start, fpu_kill, f_stall, result_valid, busy, fpu_sel, fpu_frm, result_rd});
    else n_pass++;
    step(); Rst_n = 1'b1;
  endtask

  task automatic test_add();
    issue(FP_ADD, 5'd7, 3'd2);
    n_total++;
    if (f_stall !== 1'b1 || issue_ready !== 1'b1)
      $display("FAIL add_issue_cycle: stall=%b ready=%b want 1 1", f_stall, issue_ready);
    else n_pass++;
    for (int c = 1; c <= 4; c++) begin
      step(); issue_valid = 1'b0; #1;
      n_total++;
      if (f_stall !== (c <= 2) || result_valid !== (c == 3) || fpu_start !== (c == 1))
        $display("FAIL add_cycle%0d: stall=%b rv=%b start=%b want %b %b %b", c,
                 f_stall, result_valid, fpu_start, c <= 2, c == 3, c == 1);
      else n_pass++;
      if (c == 1) begin
        n_total++;
        if (fpu_sel !== FP_ADD || fpu_frm !== 3'd2)
          $display("FAIL add_regs: sel=%0d frm=%0d want %0d 2", fpu_sel, fpu_frm, FP_ADD);
        else n_pass++;
      end
      if (c == 3) begin
        n_total++;
        if (result_rd !== 5'd7) $display("FAIL add_rd: got %0d want 7", result_rd);
        else n_pass++;
      end
    end
  endtask

  task automatic test_latency(input logic [4:0] sel, input int lat, input logic [4:0] rd);
    issue(sel, rd, 3'd0);
    n_total++;
    if (f_stall !== (lat > 1)) $display("FAIL lat%0d_issue_stall: got %b want %b", lat, f_stall, lat > 1);
    else n_pass++;
    for (int c = 1; c <= lat + 1; c++) begin
      step(); issue_valid = 1'b0; #1;
      n_total++;
      if (result_valid !== (c == lat) || f_stall !== (c < lat) || issue_ready !== (c > lat))
        $display("FAIL lat%0d_sel%0d_cycle%0d: rv=%b stall=%b ready=%b want %b %b %b", lat, sel, c,
                 result_valid, f_stall, issue_ready, c == lat, c < lat, c > lat);
      else n_pass++;
    end
  endtask

  task automatic test_div_hold();
    issue(FP_DIV, 5'd12, 3'd1);
    for (int c = 1; c <= 18; c++) begin
      step(); issue_valid = 1'b0;
      hold = (c >= 5 && c <= 6) || (c >= 12 && c <= 15);
      #1;
      n_total++;
      if (result_valid !== (c >= 12 && c <= 16) || busy !== (c <= 16) || f_stall !== (c <= 11))
        $display("FAIL div_hold_cycle%0d: rv=%b busy=%b stall=%b want %b %b %b", c,
                 result_valid, busy, f_stall, c >= 12 && c <= 16, c <= 16, c <= 11);
      else n_pass++;
    end
    hold = 1'b0;
  endtask

  task automatic test_sqrt_flush();
    issue(FP_SQRT, 5'd20, 3'd3);
    for (int c = 1; c <= 14; c++) begin
      step(); issue_valid = 1'b0; flush = (c == 6); #1;
      n_total++;
      if (result_valid !== 1'b0 || fpu_kill !== (c == 7) || busy !== (c <= 6) || issue_ready !== (c >= 7))
        $display("FAIL sqrt_flush_cycle%0d: rv=%b kill=%b busy=%b ready=%b want 0 %b %b %b", c,
                 result_valid, fpu_kill, busy, issue_ready, c == 7, c <= 6, c >= 7);
      else n_pass++;
    end
    flush = 1'b0;
  endtask

  task automatic test_flush_idle_and_done();
    issue(FP_MUL, 5'd4, 3'd0);
    flush = 1'b1; #1;
    step(); issue_valid = 1'b0; flush = 1'b0; #1;
    n_total++;
    if (busy !== 1'b0 || fpu_start !== 1'b0 || fpu_kill !== 1'b0)
      $display("FAIL flush_idle: busy=%b start=%b kill=%b want 0 0 0", busy, fpu_start, fpu_kill);
    else n_pass++;
    issue(FP_CMP, 5'd6, 3'd0);
    step(); issue_valid = 1'b0; flush = 1'b1; #1;
    n_total++;
    if (result_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL flush_done_mask: rv=%b busy=%b want 0 1", result_valid, busy);
    else n_pass++;
    step(); flush = 1'b0; #1;
    n_total++;
    if (busy !== 1'b0 || fpu_kill !== 1'b1 || result_valid !== 1'b0)
      $display("FAIL flush_done_exit: busy=%b kill=%b rv=%b want 0 1 0", busy, fpu_kill, result_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    step(); Rst_n = 1'b0; #1;
    step(); Rst_n = 1'b1;
    issue(FP_MUL, 5'd1, 3'd5);
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 1) issue_rd = 5'd2;
      if (c == 6) issue_valid = 1'b0;
      #1;
      n_total++;
      if (f_stall !== ((c <= 3) || (c >= 5 && c <= 8)) || issue_ready !== (c == 5 || c == 10) ||
          result_valid !== (c == 4 || c == 9) || fpu_start !== (c == 1 || c == 6))
        $display("FAIL b2b_cycle%0d: stall=%b ready=%b rv=%b start=%b", c,
                 f_stall, issue_ready, result_valid, fpu_start);
      else n_pass++;
      if (c == 4 || c == 9) begin
        n_total++;
        if (result_rd !== ((c == 4) ? 5'd1 : 5'd2))
          $display("FAIL b2b_rd_cycle%0d: got %0d want %0d", c, result_rd, (c == 4) ? 1 : 2);
        else n_pass++;
      end
    end
`ifdef FPU_SEQ_PERF_EN
    n_total++;
    if (perf_ops !== 32'd2 || perf_stall !== 32'd8)
      $display("FAIL perf_counts: ops=%0d stall=%0d want 2 8", perf_ops, perf_stall);
    else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_reset_mid_run();
    test_add();
    test_latency(FP_CMP, 1, 5'd3);
    test_latency(5'd31, 1, 5'd17);
    test_latency(FP_FMADD, 5, 5'd8);
    test_latency(FP_SUB, 3, 5'd11);
    test_div_hold();
    test_sqrt_flush();
    test_flush_idle_and_done();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
